// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, partial-product selects, digit recode.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of the partial product; the sign travels separately as neg.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_M    = 2'd1,
        SEL_2M   = 2'd2
    } sel_t;

    typedef struct packed {
        sel_t sel;
        logic neg;
    } booth_dig_t;

    // Radix-4 Booth recode of {q[1], q[0], q_m1}.
    function automatic booth_dig_t booth_recode(input logic [2:0] bits);
        booth_dig_t d;
        d.sel = SEL_ZERO;
        d.neg = 1'b0;
        case (bits)
            3'b001, 3'b010: d.sel = SEL_M;
            3'b011:         d.sel = SEL_2M;
            3'b100: begin
                d.sel = SEL_2M;
                d.neg = 1'b1;
            end
            3'b101, 3'b110: begin
                d.sel = SEL_M;
                d.neg = 1'b1;
            end
            default: begin
                d.sel = SEL_ZERO;
                d.neg = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_acc_add.sv
// Accumulate adder: PW-bit sum built from chained 4-bit CLA cells, carry-out discarded (wraps mod 2^PW).
// Latency: combinational, full ripple across PW/4 cells in one cycle.
// Backpressure: none.
// Ports: a, b (PW-bit addends), cin; sum (PW-bit).
module booth_acc_add #(
    parameter int PW = 16
) (
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    input  logic          cin,
    output logic [PW-1:0] sum
);

    localparam int NCELL = PW / 4;

    logic [NCELL:0] carry;
    logic           carry_unused;

    assign carry[0] = cin;

    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        cla4 u_cla4 (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (carry[i]),
            .sum  (sum[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    // Product arithmetic is modular; the final carry has no consumer.
    assign carry_unused = carry[NCELL];

endmodule

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder cell.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (4-bit addends), cin; sum (4-bit), cout.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead: every carry is a two-level function of g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential signed radix-4 Booth multiplier, one Booth digit retired per clock.
// Latency: product valid WIDTH/2 edges after the accept edge; one IDLE cycle between products.
// Backpressure: product held in DONE until out_ready; in_ready low throughout RUN and DONE.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b operand channel; out_valid/out_ready/out_p product channel.
module booth_r4_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] q;
    logic            q_m1;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;

    booth_dig_t      dig;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_sum;

    logic            load;
    logic            step;
    logic            last_step;

    assign load      = (state == IDLE) && in_valid;
    assign step      = (state == RUN);
    assign last_step = step && (cnt == CNT_LAST);

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth digit and partial-product mux
    assign dig = booth_recode({q[1:0], q_m1});

    always_comb begin
        pp = '0;
        case (dig.sel)
            SEL_M:   pp = mcand;
            SEL_2M:  pp = mcand << 1;
            default: pp = '0;
        endcase
    end

    // Negation as invert plus carry-in so the subtract shares the add chain.
    assign addend = dig.neg ? ~pp : pp;

    booth_acc_add #(
        .PW (PW)
    ) u_acc_add (
        .a   (acc),
        .b   (addend),
        .cin (dig.neg),
        .sum (acc_sum)
    );

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            out_p <= '0;
        end else if (load) begin
            mcand <= {{WIDTH{in_a[WIDTH-1]}}, in_a};
            q     <= in_b;
            q_m1  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else if (step) begin
            acc   <= acc_sum;
            mcand <= mcand << 2;
            q     <= {{2{q[WIDTH-1]}}, q[WIDTH-1:2]};
            q_m1  <= q[1];
            cnt   <= cnt + CW'(1);
            // out_p only moves on entry to DONE so the consumer sees a stable value.
            if (last_step) out_p <= acc_sum;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq.sv
module tb_booth_r4_seq;

    localparam int W      = 8;
    localparam int N_SWP  = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    int exp_q[$];
    int popped = 0;

    always #5 clk = ~clk;

    booth_r4_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Presents operands and returns #1 after the accept edge with in_valid dropped.
    task automatic issue(input int a, input int b);
        int k;
        @(negedge clk);
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance (the accept edge is edge 1) until out_valid is seen.
    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic mul_check(input string tag, input int a, input int b, input int exp);
        int l;
        issue(a, b);
        wait_valid(l);
        chk({tag, "_lat"}, l, 5);
        chk(tag, $signed(out_p), exp);
        pop();
        chk({tag, "_rdy"}, int'(in_ready), 1);
        chk({tag, "_vld_low"}, int'(out_valid), 0);
    endtask

    task automatic producer();
        int k;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < N_SWP; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            a = W'(i);
            b = W'($urandom);
            in_a     = a;
            in_b     = b;
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                chk("sweep_accept", 0, 1);
                break;
            end
            exp_q.push_back(int'($signed(a)) * int'($signed(b)));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic consumer();
        int cyc;
        int e;
        cyc = 0;
        while (popped < N_SWP && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sweep_dup", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sweep_prod", $signed(out_p), e);
                end
                popped++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("sweep_count", popped, N_SWP);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_p", int'(out_p), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3*5 with out_ready held high throughout
        out_ready = 1'b1;
        mul_check("basic_3x5", 3, 5, 15);

        // Corner operands
        mul_check("m128xm128", -128, -128, 16384);
        mul_check("p127xm128", 127, -128, -16256);
        mul_check("m1xm1", -1, -1, 1);
        mul_check("zeroxm77", 0, -77, 0);

        // Backpressure with a new operand pair waiting
        issue(-7, 9);
        wait_valid(lat);
        chk("bp_lat", lat, 5);
        in_a      = W'(11);
        in_b      = W'(-3);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_p", $signed(out_p), -63);
            chk("bp_hold_vld", int'(out_valid), 1);
            chk("bp_hold_rdy", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_pop_vld", int'(out_valid), 0);
        chk("bp_bubble_rdy", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_rdy", int'(in_ready), 0);
        wait_valid(lat);
        chk("bp_next_lat", lat, 5);
        chk("bp_next_p", $signed(out_p), -33);
        pop();

        // Reset two cycles into RUN; out_p still holds -33 beforehand
        issue(5, 5);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_p", int'(out_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mul_check("after_rst_6xm6", 6, -6, -36);

        // Randomised handshake sweep against a signed reference
        fork
            producer();
            consumer();
        join
        chk("sweep_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
